// File: rtl/cdc_event_tx_pkg.sv
// Shared types and sizing helpers for the HF_CLK-side event/snapshot crossing.
package cdc_event_tx_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } snap_state_t;

    localparam int SYNC_DEPTH = 2;

    // Width of a down-counter that must hold MIN_GAP-1; never narrower than one bit.
    function automatic int gap_w(input int min_gap);
        return (min_gap > 2) ? $clog2(min_gap) : 1;
    endfunction

endpackage

// File: rtl/cdc_evt_chan.sv
// One event channel: pulse -> rate-limited level toggle, toggle visible one cycle after emit.
// No backpressure; pulses landing during the gap are held once as pending, further ones are counted and dropped.
module cdc_evt_chan
    import cdc_event_tx_pkg::*;
#(
    parameter int MIN_GAP = 4,
    parameter int CNT_W   = 8
) (
    input  logic             HF_CLK,
    input  logic             NRST,
    input  logic             evt_pulse,
    input  logic             coal_clr,
    output logic             evt_toggle,
    output logic [CNT_W-1:0] coal_cnt
);

    localparam int             GC_W     = gap_w(MIN_GAP);
    localparam logic [GC_W-1:0] GC_LOAD = GC_W'(MIN_GAP - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [GC_W-1:0] gc;
    logic            pnd;
    logic            emit;
    logic            coalesce;

    assign emit     = (evt_pulse | pnd) && (gc == '0);
    // A pulse that finds an event already pending is lost, whether or not the pending one goes out now.
    assign coalesce = evt_pulse & pnd;

    always_ff @(posedge HF_CLK) begin
        if (!NRST) begin
            gc         <= '0;
            pnd        <= 1'b0;
            evt_toggle <= 1'b0;
            coal_cnt   <= '0;
        end else begin
            if (emit) begin
                evt_toggle <= ~evt_toggle;
                gc         <= GC_LOAD;
                pnd        <= 1'b0;
            end else if (gc != '0) begin
                gc <= gc - GC_W'(1);
                if (evt_pulse) begin
                    pnd <= 1'b1;
                end
            end

            if (coal_clr) begin
                coal_cnt <= '0;
            end else if (coalesce && (coal_cnt != CNT_MAX)) begin
                coal_cnt <= coal_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/cdc_event_tx.sv
// HF_CLK transmit side of the slow-domain crossing: event toggles plus a req/ack snapshot handshake.
// Outputs registered, 1-cycle latency; a snapshot request while busy is rejected (pulse), never queued.
module cdc_event_tx
    import cdc_event_tx_pkg::*;
#(
    parameter int N_EVT   = 2,
    parameter int MIN_GAP = 4,
    parameter int CNT_W   = 8,
    parameter int DATA_W  = 16
) (
    input  logic                   HF_CLK,
    input  logic                   NRST,
    input  logic [N_EVT-1:0]       EVT_PULSE,
    output logic [N_EVT-1:0]       EVT_TOGGLE,
    output logic [N_EVT*CNT_W-1:0] COAL_CNT,
    input  logic                   COAL_CLR,
    input  logic                   SNAP_REQ,
    input  logic [DATA_W-1:0]      SNAP_DATA,
    output logic [DATA_W-1:0]      SNAP_HOLD,
    output logic                   SNAP_REQ_TGL,
    input  logic                   SNAP_ACK_TGL,
    output logic                   SNAP_BUSY,
    output logic                   SNAP_DONE,
    output logic                   SNAP_REJECT
);

    for (genvar i = 0; i < N_EVT; i++) begin : g_chan
        cdc_evt_chan #(
            .MIN_GAP (MIN_GAP),
            .CNT_W   (CNT_W)
        ) u_chan (
            .HF_CLK     (HF_CLK),
            .NRST       (NRST),
            .evt_pulse  (EVT_PULSE[i]),
            .coal_clr   (COAL_CLR),
            .evt_toggle (EVT_TOGGLE[i]),
            .coal_cnt   (COAL_CNT[i*CNT_W +: CNT_W])
        );
    end

    logic [SYNC_DEPTH-1:0] ack_sync;
    logic                  ack_s;

    always_ff @(posedge HF_CLK) begin
        if (!NRST) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_DEPTH-2:0], SNAP_ACK_TGL};
        end
    end

    assign ack_s = ack_sync[SYNC_DEPTH-1];

    snap_state_t       state;
    snap_state_t       state_nxt;
    logic              req_tgl_nxt;
    logic [DATA_W-1:0] hold_nxt;
    logic              done_nxt;
    logic              reject_nxt;

    always_ff @(posedge HF_CLK) begin
        if (!NRST) begin
            state        <= IDLE;
            SNAP_REQ_TGL <= 1'b0;
            SNAP_HOLD    <= '0;
            SNAP_DONE    <= 1'b0;
            SNAP_REJECT  <= 1'b0;
        end else begin
            state        <= state_nxt;
            SNAP_REQ_TGL <= req_tgl_nxt;
            SNAP_HOLD    <= hold_nxt;
            SNAP_DONE    <= done_nxt;
            SNAP_REJECT  <= reject_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        req_tgl_nxt = SNAP_REQ_TGL;
        hold_nxt    = SNAP_HOLD;
        done_nxt    = 1'b0;
        reject_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (SNAP_REQ) begin
                    hold_nxt    = SNAP_DATA;
                    req_tgl_nxt = ~SNAP_REQ_TGL;
                    state_nxt   = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                // The completion cycle is still busy, so a request there is rejected too.
                if (SNAP_REQ) begin
                    reject_nxt = 1'b1;
                end
                if (ack_s == SNAP_REQ_TGL) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign SNAP_BUSY = (state == WAIT_ACK);

endmodule

// File: tb/tb_cdc_event_tx.sv
// Directed bench for cdc_event_tx: event toggling/coalescing, snapshot handshake, reset.
module tb_cdc_event_tx;

    localparam int N_EVT   = 2;
    localparam int MIN_GAP = 4;
    localparam int CNT_W   = 8;
    localparam int DATA_W  = 16;

    logic                   HF_CLK = 1'b0;
    logic                   NRST;
    logic [N_EVT-1:0]       EVT_PULSE;
    logic [N_EVT-1:0]       EVT_TOGGLE;
    logic [N_EVT*CNT_W-1:0] COAL_CNT;
    logic                   COAL_CLR;
    logic                   SNAP_REQ;
    logic [DATA_W-1:0]      SNAP_DATA;
    logic [DATA_W-1:0]      SNAP_HOLD;
    logic                   SNAP_REQ_TGL;
    logic                   SNAP_ACK_TGL;
    logic                   SNAP_BUSY;
    logic                   SNAP_DONE;
    logic                   SNAP_REJECT;

    int n_cmp = 0;
    int n_err = 0;

    cdc_event_tx #(
        .N_EVT   (N_EVT),
        .MIN_GAP (MIN_GAP),
        .CNT_W   (CNT_W),
        .DATA_W  (DATA_W)
    ) dut (
        .HF_CLK       (HF_CLK),
        .NRST         (NRST),
        .EVT_PULSE    (EVT_PULSE),
        .EVT_TOGGLE   (EVT_TOGGLE),
        .COAL_CNT     (COAL_CNT),
        .COAL_CLR     (COAL_CLR),
        .SNAP_REQ     (SNAP_REQ),
        .SNAP_DATA    (SNAP_DATA),
        .SNAP_HOLD    (SNAP_HOLD),
        .SNAP_REQ_TGL (SNAP_REQ_TGL),
        .SNAP_ACK_TGL (SNAP_ACK_TGL),
        .SNAP_BUSY    (SNAP_BUSY),
        .SNAP_DONE    (SNAP_DONE),
        .SNAP_REJECT  (SNAP_REJECT)
    );

    always #5 HF_CLK = ~HF_CLK;

    task automatic step();
        @(posedge HF_CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tgl"},    32'(EVT_TOGGLE),   32'h0);
        chk({tag, "_coal"},   32'(COAL_CNT),     32'h0);
        chk({tag, "_hold"},   32'(SNAP_HOLD),    32'h0);
        chk({tag, "_reqtgl"}, 32'(SNAP_REQ_TGL), 32'h0);
        chk({tag, "_busy"},   32'(SNAP_BUSY),    32'h0);
        chk({tag, "_done"},   32'(SNAP_DONE),    32'h0);
        chk({tag, "_reject"}, 32'(SNAP_REJECT),  32'h0);
    endtask

    initial begin
        NRST         = 1'b0;
        EVT_PULSE    = '0;
        COAL_CLR     = 1'b0;
        SNAP_REQ     = 1'b0;
        SNAP_DATA    = '0;
        SNAP_ACK_TGL = 1'b0;
        repeat (3) step();
        NRST = 1'b1;
        repeat (2) step();
        chk_all_zero("reset_idle");

        // Single pulse with the gap counter idle: toggle next cycle, nothing coalesced.
        EVT_PULSE = 2'b01;
        step();
        EVT_PULSE = 2'b00;
        chk("single_tgl", 32'(EVT_TOGGLE), 32'h1);
        chk("single_coal", 32'(COAL_CNT[7:0]), 32'h0);
        repeat (4) step();
        chk("single_hold_level", 32'(EVT_TOGGLE), 32'h1);

        // Four back-to-back pulses: emit, pend, coalesce, coalesce, then pending emit 4 cycles after the first.
        EVT_PULSE = 2'b01;
        step();
        chk("burst_first_tgl", 32'(EVT_TOGGLE), 32'h0);
        repeat (3) step();
        EVT_PULSE = 2'b00;
        chk("burst_gap_tgl", 32'(EVT_TOGGLE), 32'h0);
        chk("burst_coal", 32'(COAL_CNT[7:0]), 32'h2);
        step();
        chk("burst_pending_tgl", 32'(EVT_TOGGLE), 32'h1);
        chk("burst_ch1_coal", 32'(COAL_CNT[15:8]), 32'h0);
        repeat (4) step();

        // Channel 1 is independent of channel 0.
        EVT_PULSE = 2'b10;
        step();
        EVT_PULSE = 2'b00;
        chk("ch1_tgl", 32'(EVT_TOGGLE), 32'h3);
        chk("ch1_coal", 32'(COAL_CNT[15:8]), 32'h0);

        COAL_CLR = 1'b1;
        step();
        COAL_CLR = 1'b0;
        chk("clr_coal", 32'(COAL_CNT), 32'h0);

        // Long pulse train saturates the counter; clear during an ongoing coalesce wins.
        EVT_PULSE = 2'b01;
        for (int k = 0; k < 400; k++) step();
        chk("sat_coal", 32'(COAL_CNT[7:0]), 32'hFF);
        chk("sat_ch1_coal", 32'(COAL_CNT[15:8]), 32'h0);
        COAL_CLR = 1'b1;
        step();
        COAL_CLR  = 1'b0;
        EVT_PULSE = 2'b00;
        chk("clr_wins_coal", 32'(COAL_CNT[7:0]), 32'h0);
        repeat (5) step();
        chk("clr_stays_coal", 32'(COAL_CNT[7:0]), 32'h0);

        // Snapshot request from IDLE.
        SNAP_DATA = 16'hA5C3;
        SNAP_REQ  = 1'b1;
        step();
        SNAP_REQ = 1'b0;
        chk("snap_hold", 32'(SNAP_HOLD), 32'hA5C3);
        chk("snap_reqtgl", 32'(SNAP_REQ_TGL), 32'h1);
        chk("snap_busy", 32'(SNAP_BUSY), 32'h1);
        chk("snap_done0", 32'(SNAP_DONE), 32'h0);
        repeat (3) step();

        // Request during WAIT_ACK is rejected and does not disturb the held payload.
        SNAP_DATA = 16'h1111;
        SNAP_REQ  = 1'b1;
        step();
        SNAP_REQ = 1'b0;
        chk("rej_pulse", 32'(SNAP_REJECT), 32'h1);
        chk("rej_hold", 32'(SNAP_HOLD), 32'hA5C3);
        chk("rej_busy", 32'(SNAP_BUSY), 32'h1);
        step();
        chk("rej_clear", 32'(SNAP_REJECT), 32'h0);

        // Ack toggles; two synchronizer cycles, then completion on the next edge.
        SNAP_ACK_TGL = 1'b1;
        step();
        chk("ack_sync1_busy", 32'(SNAP_BUSY), 32'h1);
        step();
        chk("ack_sync2_busy", 32'(SNAP_BUSY), 32'h1);
        chk("ack_sync2_done", 32'(SNAP_DONE), 32'h0);
        SNAP_DATA = 16'h2222;
        SNAP_REQ  = 1'b1;
        step();
        SNAP_REQ = 1'b0;
        chk("done_busy", 32'(SNAP_BUSY), 32'h0);
        chk("done_pulse", 32'(SNAP_DONE), 32'h1);
        chk("done_rej", 32'(SNAP_REJECT), 32'h1);
        chk("done_hold", 32'(SNAP_HOLD), 32'hA5C3);

        // New request accepted the cycle right after DONE.
        SNAP_DATA = 16'hBEEF;
        SNAP_REQ  = 1'b1;
        step();
        SNAP_REQ = 1'b0;
        chk("turn_hold", 32'(SNAP_HOLD), 32'hBEEF);
        chk("turn_reqtgl", 32'(SNAP_REQ_TGL), 32'h0);
        chk("turn_busy", 32'(SNAP_BUSY), 32'h1);
        chk("turn_done", 32'(SNAP_DONE), 32'h0);
        chk("turn_rej", 32'(SNAP_REJECT), 32'h0);

        // Reset in the middle of a gap and of WAIT_ACK.
        EVT_PULSE = 2'b01;
        step();
        EVT_PULSE    = 2'b00;
        NRST         = 1'b0;
        SNAP_ACK_TGL = 1'b0;
        step();
        chk_all_zero("midrst");
        NRST = 1'b1;
        step();
        chk("postrst_busy", 32'(SNAP_BUSY), 32'h0);

        // After reset the gap counter and FSM are idle: both paths respond immediately.
        EVT_PULSE = 2'b01;
        SNAP_DATA = 16'h0F0F;
        SNAP_REQ  = 1'b1;
        step();
        EVT_PULSE = 2'b00;
        SNAP_REQ  = 1'b0;
        chk("postrst_tgl", 32'(EVT_TOGGLE), 32'h1);
        chk("postrst_hold", 32'(SNAP_HOLD), 32'h0F0F);
        chk("postrst_reqtgl", 32'(SNAP_REQ_TGL), 32'h1);
        chk("postrst_busy2", 32'(SNAP_BUSY), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
